// File: rtl/instruction_fetch_unit_if.sv
// Byte-wide instruction memory port: read strobe and address out, read byte back one cycle later.
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;

  modport master (output mem_rd, output mem_addr, input mem_rdata);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches a 32-bit instruction as four byte beats from PC_Out and hands it to decode with IF_valid.
// Optional misaligned-PC trap is enabled by defining MISALIGN_TRAP_EN.
module instruction_fetch_unit #(
  parameter int          ADDR_W    = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W-1:0]         PC_Out,
  output logic [ADDR_W-1:0]         PC_In,
  output logic                      PCWrite,
  instruction_fetch_unit_if.master  mem,
  input  logic                      id_stall,
  input  logic                      branch_taken,
  input  logic [ADDR_W-1:0]         branch_target,
  output logic [31:0]               Instruction,
  output logic [ADDR_W-1:0]         IF_PC,
  output logic                      IF_valid,
  output logic                      fetch_misaligned,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_VALID = 2'd2
`ifdef MISALIGN_TRAP_EN
    , ST_FAULT = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic [1:0]        pend_idx_q, pend_idx_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic              misalign_q, misalign_d;
  logic              misalign_hit;
  logic              mem_rd_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [ADDR_W-1:0] pc_in_c;
  logic              pcwrite_c;

`ifdef MISALIGN_TRAP_EN
  assign misalign_hit = (cnt_q == 2'd0) && (PC_Out[1:0] != 2'b00);
`else
  assign misalign_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = 1'b0;
    pend_idx_d = pend_idx_q;
    instr_d    = instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    misalign_d = misalign_q;
    mem_rd_c   = 1'b0;
    mem_addr_c = '0;
    pcwrite_c  = 1'b0;
    pc_in_c    = '0;

    // Byte requested last cycle arrives now; place it little-endian.
    if (pending_q) begin
      instr_d[{pend_idx_q, 3'b000} +: 8] = mem.mem_rdata;
    end

    case (state_q)
      ST_FETCH: begin
        if (misalign_hit) begin
`ifdef MISALIGN_TRAP_EN
          state_d    = ST_FAULT;
          misalign_d = 1'b1;
          if_valid_d = 1'b0;
`endif
        end else begin
          mem_rd_c   = 1'b1;
          mem_addr_c = PC_Out + ADDR_W'(cnt_q);
          pending_d  = 1'b1;
          pend_idx_d = cnt_q;
          cnt_d      = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if_pc_d    = PC_Out;
        if_valid_d = 1'b1;
        state_d    = ST_VALID;
      end
      ST_VALID: begin
        if (!id_stall) begin
          pcwrite_c  = 1'b1;
          pc_in_c    = PC_Out + ADDR_W'(3'd4);
          if_valid_d = 1'b0;
          state_d    = ST_FETCH;
          cnt_d      = 2'd0;
        end
      end
`ifdef MISALIGN_TRAP_EN
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
`endif
      default: state_d = ST_FETCH;
    endcase

    // A redirect overrides everything and throws away any in-flight byte.
    if (branch_taken) begin
      pcwrite_c  = 1'b1;
      pc_in_c    = branch_target;
      if_valid_d = 1'b0;
      instr_d    = NOP_INSTR;
      pending_d  = 1'b0;
      state_d    = ST_FETCH;
      cnt_d      = 2'd0;
      misalign_d = 1'b0;
    end

    // Combinational outputs read as their reset values while reset is held.
    if (reset) begin
      mem_rd_c   = 1'b0;
      mem_addr_c = '0;
      pcwrite_c  = 1'b0;
      pc_in_c    = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      cnt_q      <= 2'd0;
      pending_q  <= 1'b0;
      pend_idx_q <= 2'd0;
      instr_q    <= NOP_INSTR;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      pend_idx_q <= pend_idx_d;
      instr_q    <= instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign mem.mem_rd       = mem_rd_c;
  assign mem.mem_addr     = mem_addr_c;
  assign PCWrite          = pcwrite_c;
  assign PC_In            = pc_in_c;
  assign Instruction      = instr_q;
  assign IF_PC            = if_pc_q;
  assign IF_valid         = if_valid_q;
  assign fetch_misaligned = misalign_q;
  assign state_dbg        = state_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Consumer side of program_counter. Takes PC_Out, fetches one 32-bit instruction from a byte-wide, 1-cycle-latency synchronous instruction memory over 4 beats, and presents it to IF/ID with a valid flag.
- Drives PC_In/PCWrite back into program_counter.
- Advances PC by 4 only when decode accepts the instruction. Redirects to branch_target on branch_taken.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- NOP_INSTR, 32'h00000013, reset/flush value of Instruction (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- PC_Out  input  ADDR_W  current PC from program_counter.
- PC_In  output  ADDR_W  next PC to program_counter.
- PCWrite  output  1  PC update enable (1 = load PC_In at next edge).
- mem_rd  output  1  byte read strobe.
- mem_addr  output  ADDR_W  byte address.
- mem_rdata  input  8  read byte, valid the cycle after mem_rd.
- id_stall  input  1  decode cannot accept (hazard unit).
- branch_taken  input  1  redirect request from EX.
- branch_target  input  ADDR_W  redirect address.
- Instruction  output  32  fetched instruction.
- IF_PC  output  ADDR_W  PC of Instruction.
- IF_valid  output  1  Instruction/IF_PC valid.
- fetch_misaligned  output  1  misaligned-PC fault (see Optional Feature).

Behaviour:
- Reset (async):
  - Outputs: Instruction=NOP_INSTR, IF_PC=0, IF_valid=0, PCWrite=0, PC_In=0, mem_rd=0, mem_addr=0, fetch_misaligned=0.
  - State: state=FETCH, cnt=0, pending=0.
  - Deassertion mid-fetch restarts at FETCH cnt=0 with the PC program_counter holds (0 after reset).
- States:
  - FETCH: issue beats.
  - DRAIN: capture last byte.
  - VALID: hold instruction.
  - FAULT: only with the Optional Feature macro.
- FETCH, cnt=k (0..3):
  - mem_rd=1, mem_addr=PC_Out+k (ADDR_W wrap-around).
  - pending=1 with index k.
  - cnt++. After k=3 go to DRAIN.
- Capture: on any cycle with pending from the previous cycle, mem_rdata is written to Instruction[8i+7:8i] (little-endian, i = pending index).
- DRAIN: captures byte 3. IF_PC<=PC_Out, IF_valid<=1, then VALID.
- Latency: IF_valid rises 5 clocks after entering FETCH cnt=0.
- VALID: mem_rd=0.
  - id_stall=1: hold Instruction/IF_PC/IF_valid, PCWrite=0.
  - id_stall=0: PCWrite=1, PC_In=PC_Out+4 (combinational). Next edge: IF_valid<=0, state FETCH cnt=0. New PC_Out is used from the first FETCH cycle.
- PCWrite=0 in every other case except branch.
- branch_taken=1, any state, highest priority over id_stall and sequential advance:
  - PCWrite=1, PC_In=branch_target.
  - Next edge: IF_valid<=0, Instruction<=NOP_INSTR, pending<=0 (in-flight byte discarded), state FETCH cnt=0.
- branch_taken during DRAIN: the instruction is never marked valid.
- mem_addr/mem_rd are registered-free combinational from state, cnt and PC_Out. No other outputs change outside the rules above.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In FETCH cnt=0, if PC_Out[1:0]!=0: no mem_rd. Next edge: state FAULT, fetch_misaligned<=1, IF_valid=0, PCWrite=0.
  - FAULT holds until branch_taken (clears fetch_misaligned, redirects as above) or reset.
- Not defined:
  - fetch_misaligned tied 0.
  - Misaligned PCs are fetched bytewise at PC_Out..PC_Out+3 with no special handling.

Test Plan:
- Reset, then release with PC=0. Memory bytes 0..3 = 93,00,50,00 -> mem_addr 0,1,2,3 on cycles 0-3. IF_valid=1 on cycle 5 with Instruction=32'h00500093, IF_PC=0. PCWrite pulse with PC_In=4 in the same cycle (id_stall=0).
- id_stall=1 for 3 cycles while IF_valid -> PCWrite=0, Instruction/IF_PC stable. Release -> single PCWrite, PC_In=PC_Out+4.
- branch_taken=1, branch_target=0x100 during FETCH cnt=2 -> PCWrite=1, PC_In=0x100. Late byte ignored. Next fetch addresses 0x100..0x103. First valid Instruction contains only bytes from 0x100.
- branch_taken and id_stall=0 both asserted in VALID -> PC_In=branch_target, not PC+4.
- Async reset asserted mid-DRAIN (between edges) -> IF_valid=0, Instruction=NOP_INSTR immediately, no PCWrite.
- MISALIGN_TRAP_EN defined, PC=0x102 -> no mem_rd, fetch_misaligned=1 held. branch_taken to 0x200 clears it and fetch resumes at 0x200. Macro undefined -> bytes 0x102..0x105 fetched, fetch_misaligned=0.
